// File: rtl/wb_rom_loader.sv
// wb_rom_loader
//   Wishbone classic initiator that packs an 8-bit byte stream into 32-bit
//   little-endian words. Each word goes to consecutive word addresses from a
//   base address. An optional read-back pass compares each word after it is
//   written. Used to fill the program ROM window from an on-chip byte source.
//
// Ports
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   start                     transfer request (honoured in IDLE/DONE/ERR only)
//   base_adr, word_count      transfer setup, latched on an accepted start
//   verify                    enable read-back compare, latched on start
//   in_data/in_valid/in_ready byte stream input (valid/ready handshake)
//   wbm_*                     Wishbone classic initiator port
//   busy, done, error         transfer status levels
//   err_code                  0 none, 1 ack timeout, 2 verify mismatch
//   words_done                words fully committed so far
module wb_rom_loader #(
  parameter int unsigned CNT_W          = 10,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start,
  input  logic [31:0]      base_adr,
  input  logic [CNT_W-1:0] word_count,
  input  logic             verify,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [31:0]      wbm_adr_o,
  output logic [31:0]      wbm_dat_o,
  input  logic [31:0]      wbm_dat_i,
  input  logic             wbm_ack_i,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] words_done
);

  localparam int unsigned ADR_W = 32;
  localparam int unsigned TMO_W = 16;
  localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]       ERR_NONE    = 2'd0;
  localparam logic [1:0]       ERR_TIMEOUT = 2'd1;
  localparam logic [1:0]       ERR_VERIFY  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_WRITE   = 3'd2,
    S_READ    = 3'd3,
    S_DONE    = 3'd4,
    S_ERR     = 3'd5
  } state_t;

  state_t state, state_nxt;

  // Latched transfer setup and datapath registers
  logic [ADR_W-1:0] base_q,  base_nxt;
  logic [CNT_W-1:0] count_q, count_nxt;
  logic             verify_q, verify_nxt;
  logic [31:0]      word_q,  word_nxt;
  logic [1:0]       byte_idx, byte_idx_nxt;
  logic [TMO_W-1:0] tmo_cnt, tmo_nxt;

  // Next values of the registered outputs
  logic             in_ready_nxt;
  logic             cyc_nxt, stb_nxt, we_nxt;
  logic [3:0]       sel_nxt;
  logic [31:0]      adr_nxt, dat_nxt;
  logic             busy_nxt, done_nxt, error_nxt;
  logic [1:0]       err_code_nxt;
  logic [CNT_W-1:0] words_done_nxt;

  // Event decode
  logic             start_ok, byte_acc, last_byte, bus_ack, tmo_hit;
  logic             rd_match, last_word;
  logic [CNT_W-1:0] wd_inc;
  logic [ADR_W-1:0] word_adr;
  logic             commit, abort;
  logic [1:0]       abort_code;

  assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
  assign byte_acc  = (state == S_COLLECT) && in_valid && in_ready;
  assign last_byte = byte_acc && (byte_idx == 2'd3);
  // An ack seen while no cycle is open is ignored
  assign bus_ack   = wbm_cyc_o && wbm_stb_o && wbm_ack_i;
  // Ack in the final permitted cycle wins over the timeout
  assign tmo_hit   = wbm_stb_o && !wbm_ack_i && (tmo_cnt == TMO_LAST);
  assign rd_match  = (wbm_dat_i == wbm_dat_o);
  assign wd_inc    = words_done + CNT_W'(1);
  assign last_word = (wd_inc == count_q);
  assign word_adr  = base_q + (ADR_W'(words_done) << 2);

  // State register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_ok) begin
          state_nxt = (word_count == '0) ? S_DONE : S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (last_byte) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        if (bus_ack) begin
          if (verify_q)       state_nxt = S_READ;
          else if (last_word) state_nxt = S_DONE;
          else                state_nxt = S_COLLECT;
        end else if (tmo_hit) begin
          state_nxt = S_ERR;
        end
      end
      S_READ: begin
        if (bus_ack) begin
          if (!rd_match)      state_nxt = S_ERR;
          else if (last_word) state_nxt = S_DONE;
          else                state_nxt = S_COLLECT;
        end else if (tmo_hit) begin
          state_nxt = S_ERR;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    base_nxt       = base_q;
    count_nxt      = count_q;
    verify_nxt     = verify_q;
    word_nxt       = word_q;
    byte_idx_nxt   = byte_idx;
    tmo_nxt        = tmo_cnt;
    in_ready_nxt   = in_ready;
    cyc_nxt        = wbm_cyc_o;
    stb_nxt        = wbm_stb_o;
    we_nxt         = wbm_we_o;
    sel_nxt        = wbm_sel_o;
    adr_nxt        = wbm_adr_o;
    dat_nxt        = wbm_dat_o;
    busy_nxt       = busy;
    done_nxt       = done;
    error_nxt      = error;
    err_code_nxt   = err_code;
    words_done_nxt = words_done;
    commit         = 1'b0;
    abort          = 1'b0;
    abort_code     = ERR_NONE;

    // Counts cycles the strobe has waited for an ack
    if (wbm_stb_o && !wbm_ack_i) begin
      tmo_nxt = tmo_cnt + TMO_W'(1);
    end

    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_ok) begin
          base_nxt       = base_adr & ~32'h3;
          count_nxt      = word_count;
          verify_nxt     = verify;
          byte_idx_nxt   = 2'd0;
          done_nxt       = 1'b0;
          error_nxt      = 1'b0;
          err_code_nxt   = ERR_NONE;
          words_done_nxt = '0;
          if (word_count == '0) begin
            busy_nxt = 1'b0;
            done_nxt = 1'b1;
          end else begin
            busy_nxt     = 1'b1;
            in_ready_nxt = 1'b1;
          end
        end
      end

      S_COLLECT: begin
        if (byte_acc) begin
          word_nxt[{byte_idx, 3'b000} +: 8] = in_data;
          byte_idx_nxt = byte_idx + 2'd1;
          if (last_byte) begin
            // Launch the write with the completed word
            in_ready_nxt = 1'b0;
            cyc_nxt      = 1'b1;
            stb_nxt      = 1'b1;
            we_nxt       = 1'b1;
            sel_nxt      = 4'hF;
            adr_nxt      = word_adr;
            dat_nxt      = {in_data, word_q[23:0]};
            tmo_nxt      = '0;
          end
        end
      end

      S_WRITE: begin
        if (bus_ack) begin
          cyc_nxt = 1'b0;
          stb_nxt = 1'b0;
          we_nxt  = 1'b0;
          commit  = !verify_q;
        end else if (tmo_hit) begin
          abort      = 1'b1;
          abort_code = ERR_TIMEOUT;
        end
      end

      S_READ: begin
        if (!wbm_cyc_o) begin
          // First READ cycle is the idle gap after the write ack
          cyc_nxt = 1'b1;
          stb_nxt = 1'b1;
          we_nxt  = 1'b0;
          sel_nxt = 4'hF;
          tmo_nxt = '0;
        end else if (bus_ack) begin
          cyc_nxt = 1'b0;
          stb_nxt = 1'b0;
          if (rd_match) begin
            commit = 1'b1;
          end else begin
            abort      = 1'b1;
            abort_code = ERR_VERIFY;
          end
        end else if (tmo_hit) begin
          abort      = 1'b1;
          abort_code = ERR_TIMEOUT;
        end
      end

      default: ;
    endcase

    // Word committed: count it and either finish or gather the next word
    if (commit) begin
      words_done_nxt = wd_inc;
      if (last_word) begin
        busy_nxt = 1'b0;
        done_nxt = 1'b1;
      end else begin
        in_ready_nxt = 1'b1;
      end
    end

    // Transfer aborted: release the bus and flag the cause
    if (abort) begin
      cyc_nxt      = 1'b0;
      stb_nxt      = 1'b0;
      we_nxt       = 1'b0;
      in_ready_nxt = 1'b0;
      busy_nxt     = 1'b0;
      error_nxt    = 1'b1;
      err_code_nxt = abort_code;
    end
  end

  // Output and datapath registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      base_q     <= '0;
      count_q    <= '0;
      verify_q   <= 1'b0;
      word_q     <= '0;
      byte_idx   <= 2'd0;
      tmo_cnt    <= '0;
      in_ready   <= 1'b0;
      wbm_cyc_o  <= 1'b0;
      wbm_stb_o  <= 1'b0;
      wbm_we_o   <= 1'b0;
      wbm_sel_o  <= 4'h0;
      wbm_adr_o  <= '0;
      wbm_dat_o  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_code   <= ERR_NONE;
      words_done <= '0;
    end else begin
      base_q     <= base_nxt;
      count_q    <= count_nxt;
      verify_q   <= verify_nxt;
      word_q     <= word_nxt;
      byte_idx   <= byte_idx_nxt;
      tmo_cnt    <= tmo_nxt;
      in_ready   <= in_ready_nxt;
      wbm_cyc_o  <= cyc_nxt;
      wbm_stb_o  <= stb_nxt;
      wbm_we_o   <= we_nxt;
      wbm_sel_o  <= sel_nxt;
      wbm_adr_o  <= adr_nxt;
      wbm_dat_o  <= dat_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      error      <= error_nxt;
      err_code   <= err_code_nxt;
      words_done <= words_done_nxt;
    end
  end

endmodule
